// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port valid/ready arbiter in front of the single-port,
// 1-cycle-latency system RAM, with one registered response slot per port.
module ram_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        m0_req_valid_i,
    output logic        m0_req_ready_o,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_write_data_i,
    input  logic [3:0]  m0_write_mask_i,
    output logic        m0_resp_valid_o,
    input  logic        m0_resp_ready_i,
    output logic [31:0] m0_read_data_o,
    input  logic        m1_req_valid_i,
    output logic        m1_req_ready_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_write_data_i,
    input  logic [3:0]  m1_write_mask_i,
    output logic        m1_resp_valid_o,
    input  logic        m1_resp_ready_i,
    output logic [31:0] m1_read_data_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_write_data_o,
    output logic [3:0]  ram_write_mask_o,
    input  logic [31:0] ram_read_data_i
);

    logic             inflight_q, inflight_d;
    logic             inflight_id_q, inflight_id_d;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [1:0][31:0] resp_data_q, resp_data_d;
    logic [1:0]       eligible, grant, capture;

    // A port waits while its own access is in flight or its slot stays full.
    assign eligible[0] = m0_req_valid_i & ~(inflight_q & ~inflight_id_q)
                       & (~resp_valid_q[0] | m0_resp_ready_i);
    assign eligible[1] = m1_req_valid_i & ~(inflight_q & inflight_id_q)
                       & (~resp_valid_q[1] | m1_resp_ready_i);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        // Grant is gated by reset so no request is accepted or reaches RAM during reset.
        if (reset_ni) begin
            if (&eligible) begin
                grant = (ROUND_ROBIN && !last_grant_q) ? 2'b10 : 2'b01;
            end else begin
                grant = eligible;
            end
        end
    end

    always_comb begin
        ram_addr_o       = '0;
        ram_write_data_o = '0;
        ram_write_mask_o = '0;
        if (grant[0]) begin
            ram_addr_o       = m0_addr_i;
            ram_write_data_o = m0_write_data_i;
            ram_write_mask_o = m0_write_mask_i;
        end else if (grant[1]) begin
            ram_addr_o       = m1_addr_i;
            ram_write_data_o = m1_write_data_i;
            ram_write_mask_o = m1_write_mask_i;
        end
    end

    assign inflight_d    = |grant;
    assign inflight_id_d = grant[1];
    assign last_grant_d  = (|grant) ? grant[1] : last_grant_q;
    assign capture[0]    = inflight_q & ~inflight_id_q;
    assign capture[1]    = inflight_q & inflight_id_q;

    // Consume clears first; a coinciding capture then reloads the slot.
    always_comb begin
        resp_valid_d = resp_valid_q & ~{m1_resp_ready_i, m0_resp_ready_i};
        resp_data_d  = resp_data_q;
        for (int p = 0; p < 2; p++) begin
            if (capture[p]) begin
                resp_valid_d[p] = 1'b1;
                resp_data_d[p]  = ram_read_data_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            inflight_q    <= 1'b0;
            inflight_id_q <= 1'b0;
            last_grant_q  <= 1'b1;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
            last_grant_q  <= last_grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
        end
    end

    assign m0_req_ready_o  = grant[0];
    assign m1_req_ready_o  = grant[1];
    assign m0_resp_valid_o = resp_valid_q[0];
    assign m1_resp_valid_o = resp_valid_q[1];
    assign m0_read_data_o  = resp_data_q[0];
    assign m1_read_data_o  = resp_data_q[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed bench for ram_arbiter, checked against
// a cycle-count-based reference model of grants, responses and memory contents.
module tb_ram_arbiter;

    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Round-robin instance
    logic        m0_v = 0, m1_v = 0, m0_rr = 1, m1_rr = 1;
    logic [31:0] m0_a = 0, m1_a = 0, m0_wd = 0, m1_wd = 0;
    logic [3:0]  m0_wm = 0, m1_wm = 0;
    logic        m0_rdy, m1_rdy, m0_rv, m1_rv;
    logic [31:0] m0_rd, m1_rd, ram_a, ram_wd, ram_rd;
    logic [3:0]  ram_wm;
    logic [31:0] ram_mem [1024];

    // Fixed-priority instance
    logic        fp_m0_v = 0, fp_m1_v = 0, fp_m0_rr = 1, fp_m1_rr = 1;
    logic [31:0] fp_m0_a = 0, fp_m1_a = 0, fp_m0_wd = 0, fp_m1_wd = 0;
    logic [3:0]  fp_m0_wm = 0, fp_m1_wm = 0;
    logic        fp_m0_rdy, fp_m1_rdy, fp_m0_rv, fp_m1_rv;
    logic [31:0] fp_m0_rd, fp_m1_rd, fp_ram_a, fp_ram_wd, fp_ram_rd;
    logic [3:0]  fp_ram_wm;
    logic [31:0] fp_ram_mem [1024];

    ram_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .m0_req_valid_i(m0_v), .m0_req_ready_o(m0_rdy), .m0_addr_i(m0_a),
        .m0_write_data_i(m0_wd), .m0_write_mask_i(m0_wm), .m0_resp_valid_o(m0_rv),
        .m0_resp_ready_i(m0_rr), .m0_read_data_o(m0_rd),
        .m1_req_valid_i(m1_v), .m1_req_ready_o(m1_rdy), .m1_addr_i(m1_a),
        .m1_write_data_i(m1_wd), .m1_write_mask_i(m1_wm), .m1_resp_valid_o(m1_rv),
        .m1_resp_ready_i(m1_rr), .m1_read_data_o(m1_rd),
        .ram_addr_o(ram_a), .ram_write_data_o(ram_wd), .ram_write_mask_o(ram_wm),
        .ram_read_data_i(ram_rd)
    );

    ram_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk_i(clk), .reset_ni(rst_n),
        .m0_req_valid_i(fp_m0_v), .m0_req_ready_o(fp_m0_rdy), .m0_addr_i(fp_m0_a),
        .m0_write_data_i(fp_m0_wd), .m0_write_mask_i(fp_m0_wm), .m0_resp_valid_o(fp_m0_rv),
        .m0_resp_ready_i(fp_m0_rr), .m0_read_data_o(fp_m0_rd),
        .m1_req_valid_i(fp_m1_v), .m1_req_ready_o(fp_m1_rdy), .m1_addr_i(fp_m1_a),
        .m1_write_data_i(fp_m1_wd), .m1_write_mask_i(fp_m1_wm), .m1_resp_valid_o(fp_m1_rv),
        .m1_resp_ready_i(fp_m1_rr), .m1_read_data_o(fp_m1_rd),
        .ram_addr_o(fp_ram_a), .ram_write_data_o(fp_ram_wd), .ram_write_mask_o(fp_ram_wm),
        .ram_read_data_i(fp_ram_rd)
    );

    // Single-port, read-first, 1-cycle-latency system RAMs
    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = '0;
            fp_ram_mem[i] = '0;
        end
    end

    always @(posedge clk) begin
        ram_rd <= ram_mem[ram_a[11:2]];
        for (int b = 0; b < 4; b++)
            if (ram_wm[b]) ram_mem[ram_a[11:2]][8*b +: 8] <= ram_wd[8*b +: 8];
    end

    always @(posedge clk) begin
        fp_ram_rd <= fp_ram_mem[fp_ram_a[11:2]];
        for (int b = 0; b < 4; b++)
            if (fp_ram_wm[b]) fp_ram_mem[fp_ram_a[11:2]][8*b +: 8] <= fp_ram_wd[8*b +: 8];
    end

    // Reference model: a grant in cycle N makes the port busy until N+2, where the
    // pre-write word contents become visible and stay until the port is ready.
    typedef struct {
        logic [31:0] data;
        int          avail;
    } resp_t;

    resp_t       rq0[$], rq1[$];
    logic [31:0] ref_mem [1024];
    int          cyc, last_g, gcyc0, gcyc1;
    logic [1:0]  e_rdy, e_rv;
    logic [31:0] e_rd0, e_rd1, e_addr, e_wd;
    logic [3:0]  e_wm;

    initial for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    task automatic model_reset();
        cyc = 0;
        last_g = 1;
        gcyc0 = -10;
        gcyc1 = -10;
        rq0.delete();
        rq1.delete();
    endtask

    task automatic model_step();
        bit vis0, vis1, el0, el1;
        int g;
        logic [31:0] a, wd, old, nw;
        logic [3:0] wm;
        vis0 = (rq0.size() > 0) && (rq0[0].avail <= cyc);
        vis1 = (rq1.size() > 0) && (rq1[0].avail <= cyc);
        e_rv = {vis1, vis0};
        e_rd0 = vis0 ? rq0[0].data : 32'h0;
        e_rd1 = vis1 ? rq1[0].data : 32'h0;
        el0 = m0_v && (cyc >= gcyc0 + 2) && (!vis0 || m0_rr);
        el1 = m1_v && (cyc >= gcyc1 + 2) && (!vis1 || m1_rr);
        if (el0 && el1) g = (last_g == 0) ? 1 : 0;
        else if (el0)   g = 0;
        else if (el1)   g = 1;
        else            g = -1;
        e_rdy = {g == 1, g == 0};
        if (vis0 && m0_rr) void'(rq0.pop_front());
        if (vis1 && m1_rr) void'(rq1.pop_front());
        e_addr = '0;
        e_wd = '0;
        e_wm = '0;
        if (g >= 0) begin
            a  = (g == 0) ? m0_a : m1_a;
            wd = (g == 0) ? m0_wd : m1_wd;
            wm = (g == 0) ? m0_wm : m1_wm;
            e_addr = a;
            e_wd = wd;
            e_wm = wm;
            old = ref_mem[a[11:2]];
            nw = old;
            for (int b = 0; b < 4; b++) if (wm[b]) nw[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a[11:2]] = nw;
            if (g == 0) begin rq0.push_back(resp_t'{data: old, avail: cyc + 2}); gcyc0 = cyc; end
            else        begin rq1.push_back(resp_t'{data: old, avail: cyc + 2}); gcyc1 = cyc; end
            last_g = g;
        end
        cyc++;
    endtask

    task automatic rand_fields(output logic [31:0] a, output logic [31:0] wd, output logic [3:0] wm);
        logic [31:0] hi;
        hi = $urandom;
        a  = (hi & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        wd = $urandom;
        wm = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    endtask

    task automatic idle(input int n);
        m0_v = 0; m1_v = 0; m0_rr = 1; m1_rr = 1;
        repeat (n) begin
            @(negedge clk); model_step();
            @(posedge clk); #1;
        end
    endtask

    task automatic do_access(input int p, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] wm, output logic [31:0] got, output bit ok);
        bit granted = 0;
        ok = 0;
        got = '0;
        if (p == 0) begin m0_v = 1; m0_a = a; m0_wd = wd; m0_wm = wm; m0_rr = 1; end
        else        begin m1_v = 1; m1_a = a; m1_wd = wd; m1_wm = wm; m1_rr = 1; end
        for (int k = 0; k < TIMEOUT && !ok; k++) begin
            @(negedge clk); model_step();
            if (granted && ((p == 0) ? m0_rv : m1_rv)) begin
                got = (p == 0) ? m0_rd : m1_rd;
                ok = 1;
            end
            if (!granted && ((p == 0) ? m0_rdy : m1_rdy)) granted = 1;
            @(posedge clk); #1;
            if (granted) begin
                if (p == 0) m0_v = 0; else m1_v = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        m0_v = 1; m1_v = 1; fp_m0_v = 1; fp_m1_v = 1;
        m0_a = 32'h40; m0_wd = 32'h1234_5678; m0_wm = 4'hF;
        m1_a = 32'h44; m1_wd = 32'h8765_4321; m1_wm = 4'hF;
        @(negedge clk);
        total++;
        if ({m0_rdy, m1_rdy, m0_rv, m1_rv, fp_m0_rdy, fp_m1_rdy} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got=%b want=000000", {m0_rdy, m1_rdy, m0_rv, m1_rv, fp_m0_rdy, fp_m1_rdy});
        end
        total++;
        if ({m0_rd, m1_rd} !== 64'h0) begin
            bad++; $display("FAIL reset_read_data: got=%h want=0", {m0_rd, m1_rd});
        end
        total++;
        if ({ram_a, ram_wd, ram_wm} !== 68'h0) begin
            bad++; $display("FAIL reset_ram_outputs: got=%h want=0", {ram_a, ram_wd, ram_wm});
        end
        @(posedge clk); #1;
        m0_v = 0; m1_v = 0; fp_m0_v = 0; fp_m1_v = 0;
        m0_wm = 0; m1_wm = 0;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_single_read();
        m0_v = 1; m0_a = 32'h0; m0_wm = 4'h0; m0_rr = 1;
        @(negedge clk); model_step();
        total++;
        if ({m0_rdy, m1_rdy, ram_wm, ram_a} !== {2'b10, 4'h0, 32'h0}) begin
            bad++; $display("FAIL read0_grant: got rdy=%b%b mask=%h addr=%h want rdy=10 mask=0 addr=0", m0_rdy, m1_rdy, ram_wm, ram_a);
        end
        @(posedge clk); #1; m0_v = 0;
        @(negedge clk); model_step();
        total++;
        if (m0_rv !== 1'b0) begin bad++; $display("FAIL read0_cycle1: got resp_valid=%b want=0", m0_rv); end
        @(posedge clk); #1;
        @(negedge clk); model_step();
        total++;
        if ({m0_rv, m0_rd} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL read0_cycle2: got valid=%b data=%h want valid=1 data=00000000", m0_rv, m0_rd);
        end
        @(posedge clk); #1;
        idle(2);
    endtask

    task automatic test_write_read();
        logic [31:0] got;
        bit ok;
        do_access(0, 32'h010, 32'hDEAD_BEEF, 4'b1111, got, ok);
        total++;
        if (!ok || got !== 32'h0) begin bad++; $display("FAIL p0_write_resp: ok=%0d got=%h want=00000000", ok, got); end
        do_access(0, 32'h010, 32'h0, 4'b0000, got, ok);
        total++;
        if (!ok || got !== 32'hDEAD_BEEF) begin bad++; $display("FAIL p0_read_back: ok=%0d got=%h want=deadbeef", ok, got); end
        do_access(1, 32'h010, 32'h0000_00AA, 4'b0001, got, ok);
        total++;
        if (!ok || got !== 32'hDEAD_BEEF) begin bad++; $display("FAIL p1_write_resp: ok=%0d got=%h want=deadbeef", ok, got); end
        do_access(1, 32'h010, 32'h0, 4'b0000, got, ok);
        total++;
        if (!ok || got !== 32'hDEAD_BEAA) begin bad++; $display("FAIL p1_read_merge: ok=%0d got=%h want=deadbeaa", ok, got); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int prev = -1;
        int cur;
        m0_rr = 1; m1_rr = 1;
        rand_fields(m0_a, m0_wd, m0_wm); m0_wm = 0;
        rand_fields(m1_a, m1_wd, m1_wm); m1_wm = 0;
        m0_v = 1; m1_v = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); model_step();
            cur = m0_rdy ? 0 : (m1_rdy ? 1 : -1);
            total++;
            if ({m1_rdy, m0_rdy} !== e_rdy || cur < 0 || cur == prev) begin
                bad++; $display("FAIL b2b_grant[%0d]: got m1m0=%b%b prev=%0d want=%b alternating", k, m1_rdy, m0_rdy, prev, e_rdy);
            end
            total++;
            if ({m1_rv, m0_rv} !== e_rv || (e_rv[0] && m0_rd !== e_rd0) || (e_rv[1] && m1_rd !== e_rd1)) begin
                bad++; $display("FAIL b2b_resp[%0d]: got v=%b%b d0=%h d1=%h want v=%b d0=%h d1=%h", k, m1_rv, m0_rv, m0_rd, m1_rd, e_rv, e_rd0, e_rd1);
            end
            prev = cur;
            @(posedge clk); #1;
            if (e_rdy[0]) begin rand_fields(m0_a, m0_wd, m0_wm); m0_wm = 0; end
            if (e_rdy[1]) begin rand_fields(m1_a, m1_wd, m1_wm); m1_wm = 0; end
        end
        idle(3);
    endtask

    task automatic test_backpressure();
        m0_rr = 0; m1_rr = 1;
        m0_v = 1; m0_a = 32'h010; m0_wd = 0; m0_wm = 0;
        rand_fields(m1_a, m1_wd, m1_wm); m1_wm = 0;
        m1_v = 1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); model_step();
            total++;
            if ({m1_rdy, m0_rdy} !== e_rdy) begin
                bad++; $display("FAIL bp_grant[%0d]: got m1m0=%b%b want=%b", k, m1_rdy, m0_rdy, e_rdy);
            end
            if (e_rv[0]) begin
                total++;
                if ({m0_rv, m0_rdy, m0_rd} !== {2'b10, 32'hDEAD_BEAA}) begin
                    bad++; $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h want valid=1 ready=0 data=deadbeaa", k, m0_rv, m0_rdy, m0_rd);
                end
            end
            @(posedge clk); #1;
            if (e_rdy[0]) m0_v = 0;
            if (e_rdy[1]) begin rand_fields(m1_a, m1_wd, m1_wm); m1_wm = 0; end
        end
        idle(3);
    endtask

    task automatic test_random();
        bit g0 = 0, g1 = 0;
        for (int k = 0; k < 400; k++) begin
            if (!m0_v || g0) begin m0_v = ($urandom_range(0, 1) == 1); rand_fields(m0_a, m0_wd, m0_wm); end
            else if ($urandom_range(0, 9) == 0) m0_v = 0;
            if (!m1_v || g1) begin m1_v = ($urandom_range(0, 1) == 1); rand_fields(m1_a, m1_wd, m1_wm); end
            else if ($urandom_range(0, 9) == 0) m1_v = 0;
            m0_rr = ($urandom_range(0, 9) < 7);
            m1_rr = ($urandom_range(0, 9) < 7);
            @(negedge clk); model_step();
            total++;
            if ({m1_rdy, m0_rdy} !== e_rdy) begin
                bad++; $display("FAIL rand_grant[%0d]: got=%b%b want=%b", k, m1_rdy, m0_rdy, e_rdy);
            end
            total++;
            if ({m1_rv, m0_rv} !== e_rv || (e_rv[0] && m0_rd !== e_rd0) || (e_rv[1] && m1_rd !== e_rd1)) begin
                bad++; $display("FAIL rand_resp[%0d]: got v=%b%b d0=%h d1=%h want v=%b d0=%h d1=%h", k, m1_rv, m0_rv, m0_rd, m1_rd, e_rv, e_rd0, e_rd1);
            end
            total++;
            if ({ram_a, ram_wd, ram_wm} !== {e_addr, e_wd, e_wm}) begin
                bad++; $display("FAIL rand_ram[%0d]: got a=%h d=%h m=%h want a=%h d=%h m=%h", k, ram_a, ram_wd, ram_wm, e_addr, e_wd, e_wm);
            end
            g0 = e_rdy[0];
            g1 = e_rdy[1];
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_fixed_priority();
        logic [1:0] want;
        fp_m0_rr = 1; fp_m1_rr = 1;
        fp_m0_v = 1; fp_m0_a = 32'h0; fp_m0_wm = 0;
        @(negedge clk);
        total++;
        if ({fp_m1_rdy, fp_m0_rdy} !== 2'b01) begin bad++; $display("FAIL fp_lone: got=%b%b want=01", fp_m1_rdy, fp_m0_rdy); end
        @(posedge clk); #1; fp_m0_v = 0;
        repeat (3) @(posedge clk);
        #1;
        fp_m0_v = 1; fp_m0_a = 32'h4; fp_m1_v = 1; fp_m1_a = 32'h8; fp_m1_wm = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if ({fp_m1_rdy, fp_m0_rdy} !== want) begin
                bad++; $display("FAIL fp_grant[%0d]: got m1m0=%b%b want=%b", k, fp_m1_rdy, fp_m0_rdy, want);
            end
            @(posedge clk); #1;
        end
        #2;
        total++;
        if ({fp_m1_rv, fp_m0_rv} !== 2'b01) begin bad++; $display("FAIL fp_pre_reset: got rv=%b%b want=01", fp_m1_rv, fp_m0_rv); end
        rst_n = 0;
        #1;
        total++;
        if ({fp_m1_rv, fp_m0_rv, fp_m1_rdy, fp_m0_rdy, m1_rv, m0_rv} !== 6'b0) begin
            bad++; $display("FAIL reset_mid: got=%b want=000000", {fp_m1_rv, fp_m0_rv, fp_m1_rdy, fp_m0_rdy, m1_rv, m0_rv});
        end
        m0_v = 1; m0_a = 32'h4; m0_wm = 0; m1_v = 1; m1_a = 32'h8; m1_wm = 0;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        @(negedge clk); model_step();
        total++;
        if ({fp_m1_rdy, fp_m0_rdy} !== 2'b01) begin bad++; $display("FAIL fp_after_reset: got=%b%b want=01", fp_m1_rdy, fp_m0_rdy); end
        total++;
        if ({m1_rdy, m0_rdy} !== 2'b01) begin bad++; $display("FAIL rr_after_reset: got=%b%b want=01", m1_rdy, m0_rdy); end
        @(posedge clk); #1;
        fp_m0_v = 0; fp_m1_v = 0;
        idle(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_fixed_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
